// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: request/result bundle between the EX stage and the HI/LO
// multiply/divide unit. master = pipeline side, slave = hilo_mdu.
//
// Handshake: a request is taken on a rising edge where op_valid & op_ready &
// ~cancel. The source keeps op_valid/op_code/src_a/src_b stable until it sees
// op_ready; requests made while op_ready=0 are not queued.
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             op_ready;
    logic             busy;
    logic             stallreq;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_rdata;
    logic [WIDTH-1:0] lo_rdata;
    logic [1:0]       dbg_state;

    modport master (
        output op_valid, op_code, src_a, src_b, cancel,
        input  op_ready, busy, stallreq, done, div_by_zero,
               hi_rdata, lo_rdata, dbg_state
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, cancel,
        output op_ready, busy, stallreq, done, div_by_zero,
               hi_rdata, lo_rdata, dbg_state
    );
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO register pair with an iterative radix-2 multiply/divide
// unit (WIDTH steps per operation). FSM: IDLE -> RUN -> WB -> IDLE.
// Optional macro HILO_FAST_MUL_EN: MULT/MULTU complete in one cycle through a
// combinational multiplier; DIV/DIVU stay iterative.
// dbg_state on the interface exposes the FSM state (0 IDLE, 1 RUN, 2 WB).
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    hilo_mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // acc_hi: running product high half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    // opnd: |multiplicand| for mul, |divisor| for div
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             is_div_q, is_div_d;
    logic             is_signed_q, is_signed_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    // Request decode
    logic             accept;
    logic             is_mul_op, is_div_op, is_signed_op, start_iter;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept       = bus.op_valid & (state_q == S_IDLE) & ~bus.cancel;
    assign is_mul_op    = (bus.op_code == OP_MULT) | (bus.op_code == OP_MULTU);
    assign is_div_op    = (bus.op_code == OP_DIV)  | (bus.op_code == OP_DIVU);
    assign is_signed_op = (bus.op_code == OP_MULT) | (bus.op_code == OP_DIV);
    assign a_neg        = is_signed_op & bus.src_a[WIDTH-1];
    assign b_neg        = is_signed_op & bus.src_b[WIDTH-1];
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct magnitude unsigned
    assign a_mag        = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag        = b_neg ? -bus.src_b : bus.src_b;

`ifdef HILO_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a      = is_signed_op ? {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a}
                                     : {{WIDTH{1'b0}}, bus.src_a};
    assign ext_b      = is_signed_op ? {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b}
                                     : {{WIDTH{1'b0}}, bus.src_b};
    assign fast_prod  = ext_a * ext_b;
    assign start_iter = accept & is_div_op;
`else
    assign start_iter = accept & (is_mul_op | is_div_op);
`endif

    // Single iteration step helpers
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, opnd_q};
    // Remainder after a successful trial always fits in WIDTH bits
    assign div_rem   = div_shift[WIDTH-1:0] - opnd_q;
    assign prod_raw  = {acc_hi_q, acc_lo_q};
    assign prod_fix  = (is_signed_q & (sign_a_q ^ sign_b_q)) ? -prod_raw : prod_raw;
    assign quo_fix   = (is_signed_q & (sign_a_q ^ sign_b_q)) ? -acc_lo_q : acc_lo_q;
    assign rem_fix   = (is_signed_q & sign_a_q) ? -acc_hi_q : acc_hi_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic; cancel always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_iter) state_d = S_RUN;
            S_RUN: begin
                if (bus.cancel)              state_d = S_IDLE;
                else if (cnt_q == CNT_LAST)  state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM / register outputs
    always_comb begin
        bus.op_ready    = (state_q == S_IDLE);
        bus.busy        = (state_q != S_IDLE);
        bus.stallreq    = (state_q != S_IDLE);
        bus.done        = done_q;
        bus.div_by_zero = dbz_q;
        bus.hi_rdata    = hi_q;
        bus.lo_rdata    = lo_q;
        bus.dbg_state   = state_q;
    end

    // Datapath next values: operand load, iteration step, writeback
    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op_code == OP_MTHI) hi_d = bus.src_a;
                    if (bus.op_code == OP_MTLO) lo_d = bus.src_a;
`ifdef HILO_FAST_MUL_EN
                    if (is_mul_op) begin
                        hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                        lo_d   = fast_prod[WIDTH-1:0];
                        done_d = 1'b1;
                    end
`endif
                end
                if (start_iter) begin
                    sign_a_d    = a_neg;
                    sign_b_d    = b_neg;
                    is_div_d    = is_div_op;
                    is_signed_d = is_signed_op;
                    cnt_d       = CNT_INIT;
                    acc_hi_d    = '0;
                    opnd_d      = is_div_op ? b_mag : a_mag;
                    acc_lo_d    = is_div_op ? a_mag : b_mag;
                end
            end
            S_RUN: begin
                if (!bus.cancel) begin
                    cnt_d = cnt_q - CNT_LAST;
                    if (is_div_q) begin
                        // restoring step: shift in next dividend bit, try subtract
                        acc_hi_d = div_fits ? div_rem : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_fits};
                    end else begin
                        // shift-add step: add multiplicand on LSB, shift right
                        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                    end
                end
            end
            S_WB: begin
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (opnd_q == '0) begin
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed tests for hilo_mdu (WIDTH=32).
// Inputs change and outputs are sampled on the falling edge. Cycle numbering:
// cycle 1 is the cycle that starts at the accept edge, so an iterative op is
// busy in cycles 1..33 (RUN x32, WB x1) and done pulses in cycle 34.
module tb_hilo_mdu;
    localparam int W = 32;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;
    localparam int DIV_LAT = W + 2;
`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    hilo_mdu_if #(.WIDTH(W)) bus ();
    hilo_mdu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive_idle();
        bus.op_valid = 1'b0;
        bus.op_code  = OP_NOP;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.cancel   = 1'b0;
    endtask

    // Call at a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.src_a    = a;
        bus.src_b    = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_code  = OP_NOP;
    endtask

    // Walk falling edges until done; stall_ok drops if any earlier cycle was
    // not stalled. Bounded: a missing done returns a cycle count > 100.
    task automatic wait_done(input int start, output int cyc, output bit stall_ok, output bit dbz);
        cyc = start;
        stall_ok = 1'b1;
        dbz = 1'b0;
        while (!bus.done && cyc <= 100) begin
            if (!(bus.stallreq && bus.busy && !bus.op_ready)) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        dbz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        int cyc; bit s_ok, dbz;
        drive_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.hi_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", bus.hi_rdata, 32'h0); end
        n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.op_ready); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b done %b dbz %b want 0", bus.busy, bus.done, bus.div_by_zero); end
        rst = 1'b1;
        @(negedge clk);
        issue(OP_MTHI, 32'h55, 32'h0);
        issue(OP_MTLO, 32'h66, 32'h0);
        n_checks++; if (bus.hi_rdata !== 32'h55 || bus.lo_rdata !== 32'h66) begin n_fail++; $display("FAIL mt_pre_reset: got %h/%h want 55/66", bus.hi_rdata, bus.lo_rdata); end
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset: got %b want 1", bus.busy); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (bus.hi_rdata !== 32'h0 || bus.lo_rdata !== 32'h0) begin n_fail++; $display("FAIL async_reset_hilo: got %h/%h want 0/0", bus.hi_rdata, bus.lo_rdata); end
        n_checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0 || bus.stallreq !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl: ready %b busy %b stall %b want 1/0/0", bus.op_ready, bus.busy, bus.stallreq); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cyc = 0; s_ok = 1'b1; dbz = 1'b0;
    endtask

    task automatic test_mult();
        int cyc; bit s_ok, dbz;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (cyc !== MUL_LAT) begin n_fail++; $display("FAIL mult_latency: got %0d want %0d", cyc, MUL_LAT); end
        n_checks++; if (s_ok !== 1'b1) begin n_fail++; $display("FAIL mult_stall: stallreq dropped early"); end
        n_checks++; if (bus.hi_rdata !== 32'hFFFF_FFFF || bus.lo_rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_result: got %h_%h want ffffffff_fffffffe", bus.hi_rdata, bus.lo_rdata); end
        n_checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0 || dbz !== 1'b0) begin n_fail++; $display("FAIL mult_done_cycle: ready %b busy %b dbz %b want 1/0/0", bus.op_ready, bus.busy, dbz); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", bus.done); end
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (cyc !== MUL_LAT || s_ok !== 1'b1) begin n_fail++; $display("FAIL multu_timing: got %0d stall_ok %b want %0d 1", cyc, s_ok, MUL_LAT); end
        n_checks++; if (bus.hi_rdata !== 32'h1 || bus.lo_rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", bus.hi_rdata, bus.lo_rdata); end
        @(negedge clk);
        issue(OP_MULT, -32'sd3, -32'sd5);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.hi_rdata !== 32'h0 || bus.lo_rdata !== 32'd15) begin n_fail++; $display("FAIL mult_negneg: got %h_%h want 00000000_0000000f", bus.hi_rdata, bus.lo_rdata); end
        @(negedge clk);
        issue(OP_MULTU, 32'h1_0000, 32'h1_0000);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.hi_rdata !== 32'h1 || bus.lo_rdata !== 32'h0 || cyc !== MUL_LAT) begin n_fail++; $display("FAIL multu_2p32: got %h_%h lat %0d want 1_0 lat %0d", bus.hi_rdata, bus.lo_rdata, cyc, MUL_LAT); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int cyc; bit s_ok, dbz;
        issue(OP_DIV, -32'sd7, 32'd2);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (cyc !== DIV_LAT || s_ok !== 1'b1) begin n_fail++; $display("FAIL div_timing: got %0d stall_ok %b want %0d 1", cyc, s_ok, DIV_LAT); end
        n_checks++; if (bus.lo_rdata !== 32'hFFFF_FFFD || bus.hi_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_m7_2: got lo %h hi %h want fffffffd ffffffff", bus.lo_rdata, bus.hi_rdata); end
        @(negedge clk);
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.lo_rdata !== 32'd3 || bus.hi_rdata !== 32'd1 || dbz !== 1'b0) begin n_fail++; $display("FAIL divu_7_2: got lo %h hi %h dbz %b want 3 1 0", bus.lo_rdata, bus.hi_rdata, dbz); end
        @(negedge clk);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.lo_rdata !== 32'h8000_0000 || bus.hi_rdata !== 32'h0) begin n_fail++; $display("FAIL div_overflow: got lo %h hi %h want 80000000 0", bus.lo_rdata, bus.hi_rdata); end
        @(negedge clk);
        issue(OP_DIV, 32'd7, -32'sd2);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.lo_rdata !== 32'hFFFF_FFFD || bus.hi_rdata !== 32'd1) begin n_fail++; $display("FAIL div_7_m2: got lo %h hi %h want fffffffd 1", bus.lo_rdata, bus.hi_rdata); end
        @(negedge clk);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.lo_rdata !== 32'h0FFF_FFFF || bus.hi_rdata !== 32'hF) begin n_fail++; $display("FAIL divu_max_16: got lo %h hi %h want 0fffffff f", bus.lo_rdata, bus.hi_rdata); end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        int cyc; bit s_ok, dbz;
        issue(OP_MTHI, 32'h1234, 32'h0);
        n_checks++; if (bus.hi_rdata !== 32'h1234) begin n_fail++; $display("FAIL mthi: got %h want 1234", bus.hi_rdata); end
        issue(OP_MTLO, 32'h5678, 32'h0);
        n_checks++; if (bus.lo_rdata !== 32'h5678 || bus.hi_rdata !== 32'h1234) begin n_fail++; $display("FAIL mtlo: got hi %h lo %h want 1234 5678", bus.hi_rdata, bus.lo_rdata); end
        issue(OP_DIV, 32'd5, 32'd0);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (cyc !== DIV_LAT || dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_pulse: lat %0d dbz %b want %0d 1", cyc, dbz, DIV_LAT); end
        n_checks++; if (bus.hi_rdata !== 32'h1234 || bus.lo_rdata !== 32'h5678) begin n_fail++; $display("FAIL dbz_hilo_kept: got %h/%h want 1234/5678", bus.hi_rdata, bus.lo_rdata); end
        @(negedge clk);
        n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_width: got %b want 0", bus.div_by_zero); end
    endtask

    task automatic test_cancel();
        bit seen_done;
        issue(OP_DIVU, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        n_checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_run: ready %b busy %b want 1 0", bus.op_ready, bus.busy); end
        seen_done = 1'b0;
        repeat (40) begin
            if (bus.done) seen_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: done seen %b want 0", seen_done); end
        n_checks++; if (bus.hi_rdata !== 32'h1234 || bus.lo_rdata !== 32'h5678) begin n_fail++; $display("FAIL cancel_hilo: got %h/%h want 1234/5678", bus.hi_rdata, bus.lo_rdata); end
        bus.cancel = 1'b1;
        issue(OP_MTHI, 32'h9999, 32'h0);
        bus.cancel = 1'b0;
        n_checks++; if (bus.hi_rdata !== 32'h1234) begin n_fail++; $display("FAIL cancel_idle_drop: got %h want 1234", bus.hi_rdata); end
        issue(OP_MTHI, 32'hABCD, 32'h0);
        n_checks++; if (bus.hi_rdata !== 32'hABCD || bus.lo_rdata !== 32'h5678) begin n_fail++; $display("FAIL mthi_after_cancel: got %h/%h want abcd/5678", bus.hi_rdata, bus.lo_rdata); end
    endtask

    task automatic test_ignored();
        int cyc; bit s_ok, dbz;
        issue(OP_NOP, 32'hFFFF, 32'hFFFF);
        issue(OP_RSVD, 32'hFFFF, 32'hFFFF);
        n_checks++; if (bus.hi_rdata !== 32'hABCD || bus.lo_rdata !== 32'h5678 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL nop_rsvd: got %h/%h busy %b want abcd/5678 0", bus.hi_rdata, bus.lo_rdata, bus.busy); end
        issue(OP_DIVU, 32'd15, 32'd4);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_MTHI;
        bus.src_a    = 32'hDEAD;
        repeat (3) @(negedge clk);
        drive_idle();
        wait_done(4, cyc, s_ok, dbz);
        n_checks++; if (cyc !== DIV_LAT || bus.lo_rdata !== 32'd3 || bus.hi_rdata !== 32'd3) begin n_fail++; $display("FAIL busy_ignore: lat %0d lo %h hi %h want %0d 3 3", cyc, bus.lo_rdata, bus.hi_rdata, DIV_LAT); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; bit s_ok, dbz;
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (bus.lo_rdata !== 32'd42 || bus.hi_rdata !== 32'd0) begin n_fail++; $display("FAIL b2b_first: got lo %h hi %h want 2a 0", bus.lo_rdata, bus.hi_rdata); end
        issue(OP_DIVU, 32'd42, 32'd5);
        wait_done(1, cyc, s_ok, dbz);
        n_checks++; if (cyc !== DIV_LAT || bus.lo_rdata !== 32'd8 || bus.hi_rdata !== 32'd2) begin n_fail++; $display("FAIL b2b_second: lat %0d lo %h hi %h want %0d 8 2", cyc, bus.lo_rdata, bus.hi_rdata, DIV_LAT); end
        @(negedge clk);
    endtask

    // sequence + final report
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_cancel();
        test_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
